// File: rtl/lockin_status_capture_if.sv
// Avalon-MM slave bus and interrupt line for the lock-in status capture port.
interface lockin_status_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/lockin_status_capture.sv
// Synchronises asynchronous lock-in status lines, latches selected edges into a
// sticky W1C register and raises a masked level interrupt for the Nios II.
module lockin_status_capture #(
  parameter int               WIDTH          = 8,
  parameter int               EDGE_TYPE      = 0,
  parameter int               SYNC_STAGES    = 2,
  parameter logic [WIDTH-1:0] IRQ_MASK_RESET = {WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    reset_n,
  lockin_status_capture_if.slave  bus,
  input  logic [WIDTH-1:0]        in_port
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] sync_data_s;
  logic [WIDTH-1:0] sync_prev_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] edge_capture_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] clear_s;
  logic [WIDTH-1:0] mask_next_s;
  logic [31:0]      read_mux_s;
  logic [31:0]      readdata_r;
  logic             irq_r;
  logic             read_s;
  logic             write_s;
  logic             unused_s;

  assign sync_data_s = sync_r[SYNC_STAGES-1];
  assign read_s      = bus.chipselect & bus.write_n;
  assign write_s     = bus.chipselect & ~bus.write_n;
  assign unused_s    = ^bus.writedata;

  // Synchronizer chain plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r      <= {SYNC_STAGES{{WIDTH{1'b0}}}};
      sync_prev_r <= {WIDTH{1'b0}};
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], in_port};
      sync_prev_r <= sync_data_s;
    end
  end

  // Edge polarity selection.
  always_comb begin
    rise_s = sync_data_s & ~sync_prev_r;
    fall_s = ~sync_data_s & sync_prev_r;
    edge_s = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      32'sd0:  edge_s = rise_s;
      32'sd1:  edge_s = fall_s;
      32'sd2:  edge_s = rise_s | fall_s;
      default: edge_s = rise_s;
    endcase
  end

  // Register write decode: W1C clear vector and next mask value.
  always_comb begin
    clear_s     = {WIDTH{1'b0}};
    mask_next_s = irq_mask_r;
    if (write_s && (bus.address == 2'd3)) begin
      clear_s = bus.writedata[WIDTH-1:0];
    end else if (write_s && (bus.address == 2'd2)) begin
      mask_next_s = bus.writedata[WIDTH-1:0];
    end else begin
      clear_s     = {WIDTH{1'b0}};
      mask_next_s = irq_mask_r;
    end
  end

  // Read data multiplexer, zero-extended to the bus width.
  always_comb begin
    read_mux_s = 32'd0;
    case (bus.address)
      2'd0:    read_mux_s[WIDTH-1:0] = sync_data_s;
      2'd1:    read_mux_s = 32'd0;
      2'd2:    read_mux_s[WIDTH-1:0] = irq_mask_r;
      2'd3:    read_mux_s[WIDTH-1:0] = edge_capture_r;
      default: read_mux_s = 32'd0;
    endcase
  end

  // Sticky capture; a new edge wins over a simultaneous software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture_r <= {WIDTH{1'b0}};
      irq_mask_r     <= IRQ_MASK_RESET;
    end else begin
      edge_capture_r <= (edge_capture_r & ~clear_s) | edge_s;
      irq_mask_r     <= mask_next_s;
    end
  end

  // Registered read data and interrupt level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      if (read_s) begin
        readdata_r <= read_mux_s;
      end else begin
        readdata_r <= readdata_r;
      end
      irq_r <= |(edge_capture_r & irq_mask_r);
    end
  end

  assign bus.readdata = readdata_r;
  assign bus.irq      = irq_r;

endmodule

// File: tb/tb_lockin_status_capture.sv
// Drives rising, falling and any-edge instances with one shared stimulus and
// compares each against a history-queue model of the capture port.
module tb_lockin_status_capture;
  localparam int        SS       = 2;
  localparam logic [7:0] MASK_RST = 8'h30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wd = 32'd0;
  logic [7:0]  in_port = 8'h00;
  logic [31:0] rd [3];
  logic        irq_o [3];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    lockin_status_capture_if bif ();
    assign bif.address    = address;
    assign bif.chipselect = cs;
    assign bif.write_n    = wn;
    assign bif.writedata  = wd;
    assign rd[g]          = bif.readdata;
    assign irq_o[g]       = bif.irq;
    lockin_status_capture #(
      .WIDTH(8), .EDGE_TYPE(g), .SYNC_STAGES(SS), .IRQ_MASK_RESET(MASK_RST)
    ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bif), .in_port(in_port)
    );
  end

  // Reference model: hist[i] is in_port as sampled i+1 clock edges ago.
  logic [7:0]  hist [$];
  logic [7:0]  cap_m [3];
  logic [7:0]  mask_m [3];
  logic        irq_m [3];
  logic [31:0] rd_m [3];
  int          total = 0;
  int          bad = 0;
  int          cnt [3];

  task automatic model_reset();
    hist = {};
    for (int i = 0; i <= SS; i++) hist.push_back(8'h00);
    for (int m = 0; m < 3; m++) begin
      cap_m[m] = 8'h00; mask_m[m] = MASK_RST; irq_m[m] = 1'b0; rd_m[m] = 32'd0;
    end
  endtask

  task automatic cycle();
    logic [7:0] now_v, old_v, e, clr;
    @(posedge clk);
    now_v = hist[SS-1];
    old_v = hist[SS];
    clr = (cs && !wn && address == 2'd3) ? wd[7:0] : 8'h00;
    for (int m = 0; m < 3; m++) begin
      if (m == 0)      e = now_v & ~old_v;
      else if (m == 1) e = ~now_v & old_v;
      else             e = now_v ^ old_v;
      if (cs && wn) begin
        if (address == 2'd0)      rd_m[m] = {24'd0, now_v};
        else if (address == 2'd2) rd_m[m] = {24'd0, mask_m[m]};
        else if (address == 2'd3) rd_m[m] = {24'd0, cap_m[m]};
        else                      rd_m[m] = 32'd0;
      end
      irq_m[m] = |(cap_m[m] & mask_m[m]);
      cap_m[m] = (cap_m[m] & ~clr) | e;
      if (cs && !wn && address == 2'd2) mask_m[m] = wd[7:0];
    end
    hist.push_front(in_port);
    void'(hist.pop_back());
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wn = 1'b0; address = a; wd = d;
    cycle();
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic rdop(input logic [1:0] a);
    cs = 1'b1; wn = 1'b1; address = a;
    cycle();
    cs = 1'b0;
  endtask

  task automatic run_count(input int n);
    logic prev [3];
    for (int m = 0; m < 3; m++) prev[m] = irq_o[m];
    for (int i = 0; i < n; i++) begin
      cycle();
      for (int m = 0; m < 3; m++) begin
        if (irq_o[m] && !prev[m]) cnt[m]++;
        prev[m] = irq_o[m];
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_v;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rdop(a[1:0]);
      exp_v = (a == 2) ? {24'd0, MASK_RST} : 32'd0;
      for (int m = 0; m < 3; m++) begin
        total++;
        if (rd[m] !== exp_v || rd[m] !== rd_m[m]) begin
          bad++; $display("FAIL reset_read a%0d inst%0d got %h exp %h", a, m, rd[m], exp_v);
        end
        total++;
        if (irq_o[m] !== 1'b0) begin
          bad++; $display("FAIL reset_irq inst%0d got %b exp 0", m, irq_o[m]);
        end
      end
    end
  endtask

  task automatic test_rise_edge();
    wr(2'd2, 32'h0000_0005);
    in_port = 8'h01;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      total++;
      if (irq_o[0] !== (c >= 4)) begin
        bad++; $display("FAIL rise_irq_timing c%0d got %b exp %b", c, irq_o[0], (c >= 4));
      end
    end
    in_port = 8'h00;
    repeat (3) cycle();
    rdop(2'd3);
    total++;
    if (rd[0] !== 32'h1 || rd[0] !== rd_m[0]) begin
      bad++; $display("FAIL rise_capture got %h exp %h", rd[0], 32'h1);
    end
    rdop(2'd0);
    for (int m = 0; m < 3; m++) begin
      total++;
      if (rd[m] !== 32'd0) begin
        bad++; $display("FAIL rise_data inst%0d got %h exp 0", m, rd[m]);
      end
    end
    wr(2'd3, 32'h1);
    total++;
    if (irq_o[0] !== 1'b1) begin
      bad++; $display("FAIL w1c_irq_hold got %b exp 1", irq_o[0]);
    end
    cycle();
    for (int m = 0; m < 3; m++) begin
      total++;
      if (irq_o[m] !== irq_m[m] || irq_o[0] !== 1'b0) begin
        bad++; $display("FAIL w1c_irq_drop inst%0d got %b exp %b", m, irq_o[m], irq_m[m]);
      end
    end
  endtask

  task automatic test_mask();
    in_port = 8'h02;
    repeat (4) cycle();
    in_port = 8'h00;
    for (int c = 0; c < 4; c++) begin
      cycle();
      total++;
      if (irq_o[0] !== 1'b0) begin
        bad++; $display("FAIL mask_irq_low c%0d got %b exp 0", c, irq_o[0]);
      end
    end
    rdop(2'd3);
    total++;
    if (rd[0] !== 32'h2) begin
      bad++; $display("FAIL mask_capture got %h exp %h", rd[0], 32'h2);
    end
    wr(2'd2, 32'hFFFF_FF07);
    total++;
    if (irq_o[0] !== 1'b0) begin
      bad++; $display("FAIL mask_update_lat got %b exp 0", irq_o[0]);
    end
    cycle();
    for (int m = 0; m < 3; m++) begin
      total++;
      if (irq_o[m] !== irq_m[m] || irq_o[0] !== 1'b1) begin
        bad++; $display("FAIL mask_irq_high inst%0d got %b exp %b", m, irq_o[m], irq_m[m]);
      end
    end
    rdop(2'd2);
    total++;
    if (rd[0] !== 32'h7) begin
      bad++; $display("FAIL mask_readback got %h exp %h", rd[0], 32'h7);
    end
  endtask

  task automatic test_set_wins();
    wr(2'd3, 32'hFF);
    repeat (2) cycle();
    in_port = 8'h04;
    repeat (2) cycle();
    wr(2'd3, 32'h04);
    rdop(2'd3);
    for (int m = 0; m < 3; m++) begin
      total++;
      if (rd[m] !== rd_m[m] || rd[0][2] !== 1'b1) begin
        bad++; $display("FAIL set_wins inst%0d got %h exp %h", m, rd[m], rd_m[m]);
      end
    end
  endtask

  task automatic test_any_edge();
    in_port = 8'h00;
    wr(2'd2, 32'hFF);
    repeat (4) cycle();
    wr(2'd3, 32'hFF);
    repeat (2) cycle();
    for (int m = 0; m < 3; m++) cnt[m] = 0;
    in_port = 8'h08;
    run_count(5);
    total++;
    if (irq_o[1] !== 1'b0) begin
      bad++; $display("FAIL fall_ignores_rise got %b exp 0", irq_o[1]);
    end
    wr(2'd3, 32'hFF);
    run_count(2);
    in_port = 8'h00;
    run_count(5);
    wr(2'd3, 32'hFF);
    run_count(2);
    for (int m = 0; m < 3; m++) begin
      total++;
      if (cnt[m] !== ((m == 2) ? 2 : 1)) begin
        bad++; $display("FAIL irq_count inst%0d got %0d exp %0d", m, cnt[m], (m == 2) ? 2 : 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr(2'd2, 32'hFF);
    in_port = 8'hFF;
    repeat (5) cycle();
    in_port = 8'h00;
    repeat (5) cycle();
    rdop(2'd3);
    for (int m = 0; m < 3; m++) begin
      total++;
      if (irq_o[m] !== 1'b1 || rd[m] !== 32'hFF) begin
        bad++; $display("FAIL pre_reset inst%0d irq %b rd %h exp 1 ff", m, irq_o[m], rd[m]);
      end
    end
    in_port = 8'hFF;
    #2 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      total++;
      if (irq_o[m] !== 1'b0 || rd[m] !== 32'd0) begin
        bad++; $display("FAIL async_reset inst%0d irq %b rd %h exp 0 0", m, irq_o[m], rd[m]);
      end
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (SS + 1) cycle();
    rdop(2'd3);
    for (int m = 0; m < 3; m++) begin
      total++;
      if (rd[m] !== rd_m[m] || rd[m] !== ((m == 1) ? 32'h0 : 32'hFF)) begin
        bad++; $display("FAIL post_reset_cap inst%0d got %h exp %h", m, rd[m], rd_m[m]);
      end
    end
    wr(2'd3, 32'hFF);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      op = $urandom_range(0, 3);
      address = 2'($urandom);
      wd = $urandom;
      cs = (op != 0);
      wn = (op == 1) ? 1'b1 : (op == 0) ? 1'($urandom) : 1'b0;
      if (op == 3 && address == 2'd3) wd = 32'($urandom_range(0, 1)) << $urandom_range(0, 7);
      cycle();
      for (int m = 0; m < 3; m++) begin
        total++;
        if (rd[m] !== rd_m[m] || irq_o[m] !== irq_m[m]) begin
          bad++;
          $display("FAIL random i%0d inst%0d rd %h irq %b exp %h %b",
                   i, m, rd[m], irq_o[m], rd_m[m], irq_m[m]);
        end
      end
    end
    cs = 1'b0; wn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rise_edge();
    test_mask();
    test_set_wins();
    test_any_edge();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lockin_status_capture.md
Name: lockin_status_capture

Overview:
- Avalon-MM slave input port with edge capture and interrupt. Companion to the output-only control ports (e.g. gain setting) in the lock-in Qsys system.
- Brings asynchronous status lines from the lock-in datapath and board into the clk domain, e.g. ADC overrange, PLL lock loss, filter saturation.
- Latches edges on those lines and raises an interrupt to the Nios II so firmware can react, for example by reducing gain.

Parameters:
WIDTH, 8, number of status input bits (1..32)
EDGE_TYPE, 0, capture polarity: 0 = rising, 1 = falling, 2 = any edge
SYNC_STAGES, 2, synchronizer depth on in_port (2..4)
IRQ_MASK_RESET, 0, reset value of the interrupt mask register (WIDTH bits)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset; asserts asynchronously, all flops clear immediately
address  input  2  Avalon-MM word address
chipselect  input  1  Avalon-MM slave select
write_n  input  1  active-low write strobe; read when chipselect && write_n
writedata  input  32  write data
in_port  input  WIDTH  asynchronous status inputs
readdata  output  32  registered read data, upper bits zero
irq  output  1  registered level interrupt, active high

Behaviour:
- Reset values:
  - readdata = 0, irq = 0.
  - Synchronizer chain, delayed copy and edge_capture = 0.
  - irq_mask = IRQ_MASK_RESET.
- Synchronizer: SYNC_STAGES flops on in_port. Final stage = sync_data. One further flop = sync_prev.
- Edge detect, per bit:
  - rise = sync_data & ~sync_prev
  - fall = ~sync_data & sync_prev
  - EDGE_TYPE selects rise, fall or rise|fall.
- Edge timing (SYNC_STAGES=2): in_port stable high before clock edge k. sync_data = 1 after edge k+1. edge_capture bit set after edge k+2. irq high after edge k+3.
- Register map:
  - Addr 0 (data): read returns zero-extended sync_data. Writes ignored.
  - Addr 1 (reserved): read returns 0. Writes ignored.
  - Addr 2 (irq_mask): read/write. Write loads writedata[WIDTH-1:0]. Upper writedata bits ignored.
  - Addr 3 (edge_capture): read returns captured bits.
    - Write is write-one-to-clear: each bit i with writedata[i]=1 clears edge_capture[i]. Bits with 0 are unchanged.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, so the bit remains 1 and no edge is lost.
- Captured bits are sticky. They stay set after the input returns to its idle level until cleared by software.
- Read timing:
  - readdata registered. Value is valid the cycle after chipselect && write_n, i.e. read latency 1.
  - readdata holds its last value when not selected.
  - A read of addr 3 does not clear edge_capture.
- irq:
  - irq <= |(edge_capture & irq_mask), registered.
  - A mask write takes effect on irq one cycle after the mask register updates.
  - Clearing the last pending masked bit drops irq one cycle after edge_capture clears.
- Writes with chipselect low, and reads of any kind, have no side effects.
- After reset deassertion, an in_port held at 1 produces a rising edge on the first propagation, because sync_prev resets to 0. This is required behaviour: firmware clears edge_capture once after init.
- Reset mid-operation: all state returns to reset values immediately. Edges pending in the synchronizer are discarded.

Test Plan:
1. Reset, then read addr 0..3: readdata = 0, 0, IRQ_MASK_RESET, 0; irq = 0.
2. Rising edges (EDGE_TYPE=0):
   - Write irq_mask = 0x05, then pulse in_port[0] 0→1→0 over 5 cycles.
   - Required: edge_capture = 0x01 at edge k+2, irq = 1 at edge k+3, addr 0 reads 0.
   - Write 0x01 to addr 3: irq = 0 two cycles later.
3. Masking: pulse in_port[1] with mask 0x05. Required: edge_capture = 0x02 and irq stays 0. Then write mask 0x07: irq = 1 one cycle after the mask update.
4. Set-wins race: time an in_port[2] rising edge so its capture cycle coincides with a write of 0x04 to addr 3. Required: edge_capture[2] = 1 afterwards.
5. Falling and any-edge modes:
   - EDGE_TYPE=1: a 0→1 transition captures nothing; the following 1→0 captures.
   - EDGE_TYPE=2: both transitions capture; the count of irq assertions with clear-between equals 2.
6. Mid-operation reset: assert reset_n low while edge_capture = 0xFF and irq = 1. Required: irq and readdata are 0 immediately, asynchronously. After release with in_port = 0xFF, edge_capture = 0xFF within SYNC_STAGES+1 cycles.
